// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC vectoring post-processing path.
//
// Contents:
//   DATA_W, AMP_IN_W   widths of the phase/output magnitude and the raw magnitude
//   K_GAIN, K_FRAC     CORDIC gain compensation constant (0.60725 in Q0.12)
//   QUARTER_TURN       90 degrees in phase units (full turn = 2^DATA_W)
//   quad_id_t          original quadrant id of the vector (0..3)
//   post_in_t          one input beat of the post stage
//   s1_beat_t          payload held by pipeline stage 1
//   s2_beat_t          payload held by pipeline stage 2 (the output)
//   round_sat()        round-half-up, drop the gain fraction, saturate
package cordic_pkg;

  localparam int DATA_W   = 12;
  localparam int AMP_IN_W = 13;

  localparam int                K_FRAC = 12;
  localparam logic [K_FRAC-1:0] K_GAIN = 12'd2487;

  // Raw magnitude times gain, kept at full precision between the stages.
  localparam int PROD_W = AMP_IN_W + K_FRAC;

  // A quarter turn is 2^(DATA_W-2), so a quadrant offset is quadrant_id
  // placed in the two phase MSBs.
  localparam logic [DATA_W-1:0] QUARTER_TURN = 12'd1024;

  localparam logic [DATA_W-1:0] AMP_MAX = '1;

  // Half an output LSB expressed in product units.
  localparam logic [PROD_W:0] HALF_LSB = (PROD_W + 1)'(1) << (K_FRAC - 1);

  typedef logic [1:0] quad_id_t;

  typedef struct packed {
    logic [AMP_IN_W-1:0] amp;
    logic [DATA_W-1:0]   phase;
    quad_id_t            quadrant_id;
    logic                exchanged;
  } post_in_t;

  typedef struct packed {
    logic [DATA_W-1:0] phase;
    logic [PROD_W-1:0] prod;
  } s1_beat_t;

  typedef struct packed {
    logic [DATA_W-1:0] amp;
    logic [DATA_W-1:0] phase;
  } s2_beat_t;

  // (prod + 2^(K_FRAC-1)) >> K_FRAC, clipped to the largest DATA_W value.
  // One extra bit on the sum keeps the rounding carry from wrapping.
  function automatic logic [DATA_W-1:0] round_sat(input logic [PROD_W-1:0] prod);
    logic [PROD_W:0] sum;
    logic [PROD_W:0] shifted;
    sum     = {1'b0, prod} + HALF_LSB;
    shifted = sum >> K_FRAC;
    if (shifted > (PROD_W + 1)'(AMP_MAX)) begin
      return AMP_MAX;
    end
    return shifted[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/cordic_pipe_stage.sv
// One valid/ready register slice.
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both high. The slice accepts when it is empty or when its
// current content leaves in the same cycle; valid never depends on ready,
// and data is held while valid is high and ready is low.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   upstream handshake
//   in_data  [W]         upstream payload, sampled only on an accepted beat
//   out_valid, out_ready downstream handshake
//   out_data [W]         registered payload (zero after reset)
module cordic_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (in_ready) begin
        out_valid <= in_valid;
      end
      if (in_valid && in_ready) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/cordic_post_proc.sv
// CORDIC vectoring post-processing: undoes the pre-stage octant fold on the
// phase and removes the CORDIC gain from the magnitude, in a two-stage
// valid/ready pipeline.
//
// Handshake: a beat transfers on valid && ready at the rising edge. Each
// stage loads when empty or when its content moves on in the same cycle, so
// in_ready = !s1_valid || !s2_valid || out_ready and out_valid = s2_valid.
// Output data is held stable while out_valid && !out_ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  input handshake
//   in_amp              raw CORDIC magnitude (includes ~1.647 growth)
//   in_phase            first-octant phase, full turn = 2^DATA_W
//   in_quadrant_id      original quadrant of the vector
//   in_exchanged        pre-stage swapped re/im
//   out_valid, out_ready output handshake
//   out_amp             gain-compensated, rounded, saturated magnitude
//   out_phase           full-circle phase, full turn = 2^DATA_W
module cordic_post_proc
  import cordic_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [AMP_IN_W-1:0] in_amp,
  input  logic [DATA_W-1:0]   in_phase,
  input  logic [1:0]          in_quadrant_id,
  input  logic                in_exchanged,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_amp,
  output logic [DATA_W-1:0]   out_phase
);

  post_in_t in_beat;
  s1_beat_t s1_d;
  s1_beat_t s1_q;
  s2_beat_t s2_d;
  s2_beat_t s2_q;

  logic s1_valid;
  logic s2_in_ready;

  logic [DATA_W-1:0] p1;
  logic [DATA_W-1:0] quad_offset;

  assign in_beat = '{
    amp:         in_amp,
    phase:       in_phase,
    quadrant_id: quad_id_t'(in_quadrant_id),
    exchanged:   in_exchanged
  };

  // Inverse fold, reverse order of the pre-stage: undo the re/im swap
  // (reflection about 45 degrees), then rotate back by q quarter turns.
  // Both steps wrap modulo a full turn by construction of the width.
  always_comb begin
    p1          = in_beat.exchanged ? (QUARTER_TURN - in_beat.phase) : in_beat.phase;
    quad_offset = {in_beat.quadrant_id, {(DATA_W - 2){1'b0}}};
    s1_d.phase  = p1 + quad_offset;
    s1_d.prod   = PROD_W'(in_beat.amp) * PROD_W'(K_GAIN);
  end

  cordic_pipe_stage #(
    .W($bits(s1_beat_t))
  ) u_stage1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_d),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_q)
  );

  always_comb begin
    s2_d.amp   = round_sat(s1_q.prod);
    s2_d.phase = s1_q.phase;
  end

  cordic_pipe_stage #(
    .W($bits(s2_beat_t))
  ) u_stage2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign out_amp   = s2_q.amp;
  assign out_phase = s2_q.phase;

endmodule
